// File: rtl/sha_arb_pkg.sv
// ---------------------------------------------------------------------------
// sha_arb_pkg
// Shared definitions for the sha256 job arbiter:
//   - arb_state_t : arbiter FSM states (IDLE, START, BUSY, RESP)
//   - NUM_REQ_DEF / TIMEOUT_CYCLES_DEF : default parameter values
//   - MSG_W / HASH_W : message block and hash widths
//   - idx_width() : index width for a requester count (at least 1 bit)
// ---------------------------------------------------------------------------
package sha_arb_pkg;

    localparam int unsigned NUM_REQ_DEF        = 4;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 256;
    localparam int unsigned MSG_W              = 512;
    localparam int unsigned HASH_W             = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sha_job_arbiter_rr_select.sv
// ---------------------------------------------------------------------------
// rr_select
// Combinational round-robin winner selection.
//   i_req        : request vector
//   i_last_grant : index served last; the search starts one above it
//   o_winner     : first requesting index found, wrapping modulo NUM_REQ
//   o_any_req    : at least one request bit is set
// ---------------------------------------------------------------------------
module rr_select
    import sha_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = NUM_REQ_DEF,
    localparam int unsigned IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last_grant,
    output logic [IDX_W-1:0]   o_winner,
    output logic               o_any_req
);

    logic [IDX_W-1:0] w_idx;
    logic             w_found;

    // Walk last_grant+1, last_grant+2, ... and keep the first hit, so the
    // requester served last has the lowest priority next time.
    always_comb begin
        o_winner = '0;
        w_found  = 1'b0;
        w_idx    = '0;
        for (int i = 1; i <= int'(NUM_REQ); i++) begin
            w_idx = IDX_W'((int'(i_last_grant) + i) % int'(NUM_REQ));
            if (!w_found && i_req[w_idx]) begin
                o_winner = w_idx;
                w_found  = 1'b1;
            end
        end
    end

    assign o_any_req = |i_req;

endmodule

// File: rtl/sha_job_arbiter.sv
// ---------------------------------------------------------------------------
// sha_job_arbiter
// Shares one sha256 compression core between NUM_REQ requesters.
// A winner is picked round-robin in IDLE, its message/hash are registered
// toward the core, the core is started, and the result is returned on a
// shared bus with a one-hot valid held until the winner accepts it.
//
// Ports:
//   clk, reset_n              : clock, asynchronous active-low reset
//   req / req_msg / req_hash  : per-requester job request and data
//   gnt                       : one-hot, one-cycle grant pulse
//   rsp_valid / rsp_ready     : one-hot response handshake
//   rsp_hash / rsp_err        : result hash and timeout flag
//   core_start / core_msg / core_hash_in : job issued to the core
//   core_done / core_hash_out : core completion and result
//
// Optional feature: define SHA_ARB_TIMEOUT_EN to build a BUSY watchdog of
// TIMEOUT_CYCLES cycles; without it rsp_err is constant 0 and BUSY waits
// for core_done indefinitely.
// ---------------------------------------------------------------------------
module sha_job_arbiter
    import sha_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = NUM_REQ_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*MSG_W-1:0]  req_msg,
    input  logic [NUM_REQ*HASH_W-1:0] req_hash,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [HASH_W-1:0]         rsp_hash,
    output logic                      rsp_err,
    output logic                      core_start,
    output logic [MSG_W-1:0]          core_msg,
    output logic [HASH_W-1:0]         core_hash_in,
    input  logic                      core_done,
    input  logic [HASH_W-1:0]         core_hash_out
);

    localparam int unsigned        IDX_W     = idx_width(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE_HOT_0 = NUM_REQ'(1);

    arb_state_t         r_state;
    arb_state_t         w_state_next;
    logic [IDX_W-1:0]   r_winner;
    logic [IDX_W-1:0]   r_last_grant;
    logic [NUM_REQ-1:0] r_gnt;
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [HASH_W-1:0]  r_rsp_hash;
    logic               r_core_start;
    logic [MSG_W-1:0]   r_core_msg;
    logic [HASH_W-1:0]  r_core_hash_in;

    logic [IDX_W-1:0]   w_winner;
    logic               w_any_req;
    logic               w_load_job;
    logic               w_start_job;
    logic               w_take_done;
    logic               w_take_timeout;
    logic               w_release;
    logic               w_timeout;

    logic [MSG_W-1:0]   w_msg_arr  [NUM_REQ];
    logic [HASH_W-1:0]  w_hash_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_msg_arr[gi]  = req_msg[gi*MSG_W +: MSG_W];
        assign w_hash_arr[gi] = req_hash[gi*HASH_W +: HASH_W];
    end

    rr_select #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_select (
        .i_req        (req),
        .i_last_grant (r_last_grant),
        .o_winner     (w_winner),
        .o_any_req    (w_any_req)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // core_done takes priority over the watchdog when both land together.
    always_comb begin
        w_state_next   = r_state;
        w_load_job     = 1'b0;
        w_start_job    = 1'b0;
        w_take_done    = 1'b0;
        w_take_timeout = 1'b0;
        w_release      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_load_job   = 1'b1;
                    w_state_next = START;
                end
            end
            START: begin
                w_start_job  = 1'b1;
                w_state_next = BUSY;
            end
            BUSY: begin
                if (core_done) begin
                    w_take_done  = 1'b1;
                    w_state_next = RESP;
                end else if (w_timeout) begin
                    w_take_timeout = 1'b1;
                    w_state_next   = RESP;
                end
            end
            RESP: begin
                if (rsp_ready[r_winner]) begin
                    w_release    = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_winner       <= '0;
            r_last_grant   <= IDX_W'(NUM_REQ - 1);
            r_gnt          <= '0;
            r_rsp_valid    <= '0;
            r_rsp_hash     <= '0;
            r_core_start   <= 1'b0;
            r_core_msg     <= '0;
            r_core_hash_in <= '0;
        end else begin
            r_gnt        <= '0;
            r_core_start <= w_start_job;
            if (w_load_job) begin
                r_winner       <= w_winner;
                r_gnt          <= ONE_HOT_0 << w_winner;
                r_core_msg     <= w_msg_arr[w_winner];
                r_core_hash_in <= w_hash_arr[w_winner];
            end
            if (w_take_done) begin
                r_rsp_hash  <= core_hash_out;
                r_rsp_valid <= ONE_HOT_0 << r_winner;
            end else if (w_take_timeout) begin
                r_rsp_hash  <= '0;
                r_rsp_valid <= ONE_HOT_0 << r_winner;
            end
            if (w_release) begin
                r_rsp_valid  <= '0;
                r_last_grant <= r_winner;
            end
        end
    end

`ifdef SHA_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_rsp_err;

    // Counter is zero in the first BUSY cycle and equals k in BUSY cycle k.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            if (w_start_job) begin
                r_cnt <= '0;
            end else if (r_state == BUSY) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_take_done) begin
                r_rsp_err <= 1'b0;
            end else if (w_take_timeout) begin
                r_rsp_err <= 1'b1;
            end
        end
    end

    assign w_timeout = (r_state == BUSY) && (r_cnt == CNT_W'(TIMEOUT_CYCLES));
    assign rsp_err   = r_rsp_err;
`else
    assign w_timeout = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    assign gnt          = r_gnt;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_hash     = r_rsp_hash;
    assign core_start   = r_core_start;
    assign core_msg     = r_core_msg;
    assign core_hash_in = r_core_hash_in;

endmodule

// File: doc/sha_job_arbiter.md
SHA_JOB_ARBITER -- requirements
Module: sha_job_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one sha256 compression core.
REQ-002 Parameter TIMEOUT_CYCLES, default 256: BUSY-state watchdog limit; used only when SHA_ARB_TIMEOUT_EN is defined.
REQ-003 Ports SHALL be, clock and reset first:
- clk  in  1  single clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester job request, level.
- req_msg  in  NUM_REQ x 512  per-requester 16-word message block.
- req_hash  in  NUM_REQ x 256  per-requester input hash h0..h7.
- gnt  out  NUM_REQ  one-hot, one-cycle grant pulse.
- rsp_valid  out  NUM_REQ  one-hot response valid.
- rsp_ready  in  NUM_REQ  per-requester response accept.
- rsp_hash  out  256  result hash, shared bus.
- rsp_err  out  1  timeout flag, qualified by rsp_valid.
- core_start  out  1  one-cycle start pulse to the core.
- core_msg  out  512  registered message to the core.
- core_hash_in  out  256  registered input hash to the core.
- core_done  in  1  core completion, one-cycle pulse.
- core_hash_out  in  256  core result, valid with core_done.

Function
REQ-004 FSM states SHALL be IDLE, START, BUSY and RESP.
REQ-005 In IDLE with any req bit set: select the winner round-robin, searching from last_grant+1 modulo NUM_REQ; latch req_msg and req_hash of the winner into core_msg and core_hash_in; pulse gnt[winner] for one cycle; go to START.
REQ-006 In START: assert core_start for exactly one cycle; go to BUSY.
REQ-007 In BUSY on core_done: register core_hash_out into rsp_hash, set rsp_err=0, go to RESP.
REQ-008 In RESP: hold rsp_valid[winner] high and rsp_hash stable until rsp_ready[winner]=1; on that cycle set last_grant=winner, clear rsp_valid and go to IDLE.
REQ-009 Latency: gnt appears 1 cycle after req is sampled in IDLE; core_start appears 1 cycle after gnt; rsp_valid appears 1 cycle after core_done.
REQ-010 req is sampled only in IDLE; req bits in START, BUSY or RESP are ignored. A requester SHALL deassert req after gnt, or it re-competes in the next IDLE.
REQ-011 core_done outside BUSY SHALL be ignored.
REQ-012 rsp_ready to a non-granted index, or outside RESP, SHALL be ignored.
REQ-013 Back-to-back jobs: minimum turnaround RESP to IDLE to gnt is 1 cycle in IDLE.
REQ-014 A single persistent requester SHALL be served repeatedly; with all requesters active, grants SHALL rotate 0,1,2,3,0, ...

Reset
REQ-015 On reset_n=0, asynchronously: state=IDLE, gnt=0, rsp_valid=0, rsp_err=0, rsp_hash=0, core_start=0, core_msg=0, core_hash_in=0, timeout counter=0, last_grant=NUM_REQ-1.
REQ-016 Reset in any state SHALL abandon the job in flight; no rsp_valid is issued for it.

Configuration
REQ-017 With SHA_ARB_TIMEOUT_EN defined:
- a counter clears on entry to BUSY and increments each BUSY cycle.
- on reaching TIMEOUT_CYCLES without core_done, go to RESP with rsp_err=1 and rsp_hash=0.
- if core_done and the limit coincide, core_done wins and rsp_err=0.
REQ-018 Without SHA_ARB_TIMEOUT_EN: no counter is built, rsp_err is tied to 0, and BUSY waits indefinitely.

Structure
REQ-019 Shared package sha_arb_pkg SHALL hold the FSM state enum, the default NUM_REQ and TIMEOUT_CYCLES, and the width constants MSG_W=512 and HASH_W=256.
REQ-020 Round-robin selection SHALL be a sub-module rr_select: inputs req and last_grant; outputs winner index and any_req; combinational.

Verification
REQ-021 Single request: req=0001, core_done 65 cycles after core_start, core_hash_out=256'hA5...A5 -> gnt=0001 at cycle 1, core_start at cycle 2, rsp_valid=0001 with rsp_hash=A5...A5 and rsp_err=0.
REQ-022 All four requesting continuously, core_done 3 cycles after each start, rsp_ready tied high -> gnt sequence 0001,0010,0100,1000,0001.
REQ-023 rsp_ready held low for 10 cycles -> rsp_valid and rsp_hash stable for all 10 cycles; no new gnt during that time.
REQ-024 Spurious core_done in IDLE, and req=0010 asserted during BUSY -> both ignored; req is serviced only after RESP completes.
REQ-025 reset_n pulsed low during BUSY -> all outputs 0 immediately; the next req=0001 is granted index 0.
REQ-026 With SHA_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, core_done never asserted -> rsp_valid 9 cycles after core_start with rsp_err=1 and rsp_hash=0; repeated with core_done on the limit cycle -> rsp_err=0.
